// File: rtl/bus_load_unit.sv
// bus_load_unit: receiving end of the common 16-bit bus.
// Decodes a destination select and loads the bus into AR, PC, DR, AC or IR.
// It also applies clear/increment micro-ops to those registers.
// A bus-to-memory transfer becomes a handshaked write (mem_we/mem_ack) at address AR.
// Optional feature macro: MEM_WR_TIMEOUT_EN. When it is defined, a write that never
// sees mem_ack gives up after TIMEOUT cycles and sets the sticky mem_err flag.
module bus_load_unit #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus,
    input  logic [2:0]        dst_sel,
    input  logic              ld_en,
    input  logic              inc_ar,
    input  logic              inc_pc,
    input  logic              inc_dr,
    input  logic              clr_ar,
    input  logic              clr_pc,
    input  logic              clr_dr,
    input  logic              clr_ac,
    output logic [ADDR_W-1:0] ar_q,
    output logic [ADDR_W-1:0] pc_q,
    output logic [DATA_W-1:0] dr_q,
    output logic [DATA_W-1:0] ac_q,
    output logic [DATA_W-1:0] ir_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic              busy,
    output logic              mem_err
);

    localparam logic [2:0] SEL_AR  = 3'b001;
    localparam logic [2:0] SEL_PC  = 3'b010;
    localparam logic [2:0] SEL_DR  = 3'b011;
    localparam logic [2:0] SEL_AC  = 3'b100;
    localparam logic [2:0] SEL_IR  = 3'b101;
    localparam logic [2:0] SEL_MEM = 3'b110;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [ADDR_W-1:0] ar_reg, ar_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] dr_reg, dr_next;
    logic [DATA_W-1:0] ac_reg, ac_next;
    logic [DATA_W-1:0] ir_reg, ir_next;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_wdata_reg;

    // Register updates are only allowed while no write is outstanding.
    logic upd_en;
    logic write_start;
    logic timeout_hit;

    assign upd_en      = (state_reg == ST_IDLE);
    assign write_start = upd_en && ld_en && (dst_sel == SEL_MEM);

    // Per-destination load strobes.
    logic ld_ar, ld_pc, ld_dr, ld_ac, ld_ir;
    assign ld_ar = ld_en && (dst_sel == SEL_AR);
    assign ld_pc = ld_en && (dst_sel == SEL_PC);
    assign ld_dr = ld_en && (dst_sel == SEL_DR);
    assign ld_ac = ld_en && (dst_sel == SEL_AC);
    assign ld_ir = ld_en && (dst_sel == SEL_IR);

`ifdef MEM_WR_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             mem_err_reg;

    // The last ack-less WRITE cycle; an ack on this same edge still wins.
    assign timeout_hit = (state_reg == ST_WRITE) && !mem_ack
                         && (cnt_reg == CNT_W'(TIMEOUT - 1));

    // Count WRITE cycles without ack, restarting at every write entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (write_start) begin
            cnt_reg <= '0;
        end else if ((state_reg == ST_WRITE) && !mem_ack) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Sticky error: set by a timeout, cleared when the next MEM load is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err_reg <= 1'b0;
        end else if (write_start) begin
            mem_err_reg <= 1'b0;
        end else if (timeout_hit) begin
            mem_err_reg <= 1'b1;
        end
    end

    assign mem_err = mem_err_reg;
`else
    assign timeout_hit = 1'b0;
    assign mem_err     = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (write_start) begin
                    state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (mem_ack || timeout_hit) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: the write request and the busy flag are both "in WRITE".
    always_comb begin
        mem_we = 1'b0;
        busy   = 1'b0;
        if (state_reg == ST_WRITE) begin
            mem_we = 1'b1;
            busy   = 1'b1;
        end
    end

    // AR/PC next values: clear beats load beats increment; loads take the low bus bits.
    always_comb begin
        ar_next = ar_reg;
        pc_next = pc_reg;
        if (upd_en) begin
            if (clr_ar) begin
                ar_next = '0;
            end else if (ld_ar) begin
                ar_next = bus[ADDR_W-1:0];
            end else if (inc_ar) begin
                ar_next = ar_reg + 1'b1;
            end

            if (clr_pc) begin
                pc_next = '0;
            end else if (ld_pc) begin
                pc_next = bus[ADDR_W-1:0];
            end else if (inc_pc) begin
                pc_next = pc_reg + 1'b1;
            end
        end
    end

    // DR/AC/IR next values with the same clear > load > increment priority.
    always_comb begin
        dr_next = dr_reg;
        ac_next = ac_reg;
        ir_next = ir_reg;
        if (upd_en) begin
            if (clr_dr) begin
                dr_next = '0;
            end else if (ld_dr) begin
                dr_next = bus;
            end else if (inc_dr) begin
                dr_next = dr_reg + 1'b1;
            end

            if (clr_ac) begin
                ac_next = '0;
            end else if (ld_ac) begin
                ac_next = bus;
            end

            if (ld_ir) begin
                ir_next = bus;
            end
        end
    end

    // Architectural register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ar_reg <= '0;
            pc_reg <= '0;
            dr_reg <= '0;
            ac_reg <= '0;
            ir_reg <= '0;
        end else begin
            ar_reg <= ar_next;
            pc_reg <= pc_next;
            dr_reg <= dr_next;
            ac_reg <= ac_next;
            ir_reg <= ir_next;
        end
    end

    // Write address/data are latched on entry; AR is taken before its own same-edge update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
        end else if (write_start) begin
            mem_addr_reg  <= ar_reg;
            mem_wdata_reg <= bus;
        end
    end

    assign ar_q      = ar_reg;
    assign pc_q      = pc_reg;
    assign dr_q      = dr_reg;
    assign ac_q      = ac_reg;
    assign ir_q      = ir_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;

endmodule

// File: tb/tb_bus_load_unit.sv
// tb_bus_load_unit: directed scenarios plus randomized traffic for bus_load_unit,
// checked every cycle against a behavioural model of the register/write rules.
// Honors MEM_WR_TIMEOUT_EN the same way the design does.
module tb_bus_load_unit;

    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bus = '0;
    logic [2:0]  dst_sel = '0;
    logic        ld_en = 1'b0;
    logic        inc_ar = 1'b0, inc_pc = 1'b0, inc_dr = 1'b0;
    logic        clr_ar = 1'b0, clr_pc = 1'b0, clr_dr = 1'b0, clr_ac = 1'b0;
    logic        mem_ack = 1'b0;
    logic [11:0] ar_q, pc_q, mem_addr;
    logic [15:0] dr_q, ac_q, ir_q, mem_wdata;
    logic        mem_we, busy, mem_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_ar, m_pc, m_dr, m_ac, m_ir;
    int m_waddr, m_wdata, m_wcnt;
    bit m_writing, m_err;

    bus_load_unit #(.ADDR_W(12), .DATA_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .dst_sel(dst_sel), .ld_en(ld_en),
        .inc_ar(inc_ar), .inc_pc(inc_pc), .inc_dr(inc_dr),
        .clr_ar(clr_ar), .clr_pc(clr_pc), .clr_dr(clr_dr), .clr_ac(clr_ac),
        .ar_q(ar_q), .pc_q(pc_q), .dr_q(dr_q), .ac_q(ac_q), .ir_q(ir_q),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ack(mem_ack), .busy(busy), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ar = 0; m_pc = 0; m_dr = 0; m_ac = 0; m_ir = 0;
        m_waddr = 0; m_wdata = 0; m_wcnt = 0;
        m_writing = 0; m_err = 0;
    endtask

    // One clock edge of the specified behaviour, using the inputs as driven.
    task automatic m_step();
        int b;
        b = int'(bus);
        if (m_writing) begin
            if (mem_ack) begin
                m_writing = 0;
            end else begin
                m_wcnt++;
`ifdef MEM_WR_TIMEOUT_EN
                if (m_wcnt == TIMEOUT) begin
                    m_writing = 0;
                    m_err = 1;
                end
`endif
            end
        end else begin
            if (ld_en && dst_sel == 3'd6) begin
                m_writing = 1;
                m_waddr = m_ar;
                m_wdata = b;
                m_wcnt = 0;
                m_err = 0;
            end
            if (clr_ar) m_ar = 0;
            else if (ld_en && dst_sel == 3'd1) m_ar = b % 4096;
            else if (inc_ar) m_ar = (m_ar + 1) % 4096;
            if (clr_pc) m_pc = 0;
            else if (ld_en && dst_sel == 3'd2) m_pc = b % 4096;
            else if (inc_pc) m_pc = (m_pc + 1) % 4096;
            if (clr_dr) m_dr = 0;
            else if (ld_en && dst_sel == 3'd3) m_dr = b;
            else if (inc_dr) m_dr = (m_dr + 1) % 65536;
            if (clr_ac) m_ac = 0;
            else if (ld_en && dst_sel == 3'd4) m_ac = b;
            if (ld_en && dst_sel == 3'd5) m_ir = b;
        end
    endtask

    task automatic compare_all();
        chk("ar_q", int'(ar_q), m_ar);
        chk("pc_q", int'(pc_q), m_pc);
        chk("dr_q", int'(dr_q), m_dr);
        chk("ac_q", int'(ac_q), m_ac);
        chk("ir_q", int'(ir_q), m_ir);
        chk("mem_we", int'(mem_we), int'(m_writing));
        chk("busy", int'(busy), int'(m_writing));
        chk("mem_err", int'(mem_err), int'(m_err));
        chk("mem_addr", int'(mem_addr), m_waddr);
        chk("mem_wdata", int'(mem_wdata), m_wdata);
    endtask

    // Advance one cycle: model follows the edge, outputs compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        compare_all();
        $display("cyc t=%0t ld=%0b sel=%0d bus=%h ack=%0b | ar=%h pc=%h dr=%h ac=%h ir=%h we=%0b err=%0b",
                 $time, ld_en, dst_sel, bus, mem_ack, ar_q, pc_q, dr_q, ac_q, ir_q, mem_we, mem_err);
    endtask

    task automatic idle_inputs();
        ld_en = 0; dst_sel = 0; bus = 0; mem_ack = 0;
        inc_ar = 0; inc_pc = 0; inc_dr = 0;
        clr_ar = 0; clr_pc = 0; clr_dr = 0; clr_ac = 0;
    endtask

    task automatic load(input logic [2:0] sel, input logic [15:0] val);
        ld_en = 1; dst_sel = sel; bus = val;
    endtask

    initial begin
        m_reset();
        repeat (2) @(negedge clk);
        rst_n = 1;
        compare_all();
        chk("reset_ar", int'(ar_q), 0);
        chk("reset_busy", int'(busy), 0);

        // 1: AR load ignores upper bus bits
        load(3'd1, 16'hF123);
        tick();
        chk("t1_ar", int'(ar_q), 12'h123);
        chk("t1_pc", int'(pc_q), 0);

        // 2: PC wrap, then clear beats load on AC
        load(3'd2, 16'hFFFF);
        tick();
        idle_inputs(); inc_pc = 1;
        tick();
        chk("t2_pc_wrap", int'(pc_q), 0);
        idle_inputs(); load(3'd4, 16'h1234);
        tick();
        chk("t2_ac_load", int'(ac_q), 16'h1234);
        load(3'd4, 16'h5A5A); clr_ac = 1;
        tick();
        chk("t2_ac_clr_wins", int'(ac_q), 0);

        // 3: memory write with same-edge AR increment, DR load ignored while busy
        idle_inputs(); load(3'd1, 16'h0040);
        tick();
        load(3'd6, 16'hBEEF); inc_ar = 1;
        tick();
        chk("t3_we", int'(mem_we), 1);
        chk("t3_addr", int'(mem_addr), 12'h040);
        chk("t3_wdata", int'(mem_wdata), 16'hBEEF);
        chk("t3_ar", int'(ar_q), 12'h041);
        idle_inputs(); load(3'd3, 16'h1111);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_busy_hold", int'(busy), 1);
            chk("t3_dr_frozen", int'(dr_q), 0);
        end
        mem_ack = 1;
        tick();
        chk("t3_we_drop", int'(mem_we), 0);
        chk("t3_busy_drop", int'(busy), 0);
        chk("t3_dr_still", int'(dr_q), 0);

        // 4: asynchronous reset in the middle of a write
        idle_inputs(); load(3'd6, 16'hCAFE);
        tick();
        chk("t4_we_before", int'(mem_we), 1);
        idle_inputs();
        #2 rst_n = 0;
        #1;
        chk("t4_we_async", int'(mem_we), 0);
        chk("t4_ar_async", int'(ar_q), 0);
        m_reset();
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("t4_busy_after", int'(busy), 0);
        chk("t4_ac_after", int'(ac_q), 0);

`ifdef MEM_WR_TIMEOUT_EN
        // 5: write timeout sets the sticky error; next accepted write clears it
        load(3'd6, 16'h7777);
        tick();
        idle_inputs();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("t5_busy_last", int'(busy), 1);
        tick();
        chk("t5_busy_timeout", int'(busy), 0);
        chk("t5_err_set", int'(mem_err), 1);
        load(3'd6, 16'h8888); mem_ack = 1;
        tick();
        chk("t5_err_clr", int'(mem_err), 0);
        tick();
        chk("t5_done", int'(busy), 0);
`endif

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ld_en   = ($urandom_range(0, 9) < 6);
            dst_sel = 3'($urandom_range(0, 7));
            bus     = 16'($urandom);
            inc_ar  = ($urandom_range(0, 5) == 0);
            inc_pc  = ($urandom_range(0, 5) == 0);
            inc_dr  = ($urandom_range(0, 5) == 0);
            clr_ar  = ($urandom_range(0, 7) == 0);
            clr_pc  = ($urandom_range(0, 7) == 0);
            clr_dr  = ($urandom_range(0, 7) == 0);
            clr_ac  = ($urandom_range(0, 7) == 0);
            mem_ack = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
